// File: rtl/seq_detector_n_pkg.sv
// Shared constants and helpers for the parametrised serial sequence detector.
package seq_det_pkg;

    localparam bit MODE_MOORE = 1'b1;
    localparam bit MODE_MEALY = 1'b0;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;

    // Elaboration-time legality test for the pattern length.
    function automatic bit pat_w_legal(input int w);
        return (w >= PAT_W_MIN) && (w <= PAT_W_MAX);
    endfunction

endpackage

// File: rtl/seq_detector_n_if.sv
// Serial stream, pattern reload and detect/status signals of seq_detector_n.
interface seq_detector_n_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             in_i;
    logic             en_i;
    logic             pat_load_i;
    logic [PAT_W-1:0] pat_in_i;
    logic             out_o;
    logic [CNT_W-1:0] match_cnt_o;

    modport master (
        output in_i, en_i, pat_load_i, pat_in_i,
        input  out_o, match_cnt_o
    );

    modport slave (
        input  in_i, en_i, pat_load_i, pat_in_i,
        output out_o, match_cnt_o
    );
endinterface

// File: rtl/seq_detector_n_sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector_n.sv
// Parametrised serial sequence detector with run-time pattern reload,
// selectable overlap handling and Moore/Mealy detect output.
//
// The fill counter is the FSM state:
//   fill      | meaning
//   0         | no bits collected toward a match
//   1..PAT_W-2| partial prefix collected
//   PAT_W-1   | next sampled bit may complete a match
//   PAT_W     | window full, every sample is a candidate
module seq_detector_n #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter bit               MOORE   = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    seq_detector_n_if.slave bus
);
    import seq_det_pkg::*;

    if (!pat_w_legal(PAT_W)) begin : g_pat_w_check
        $error("seq_detector_n: PAT_W must be within 2..16");
    end

    localparam int FILL_W = $clog2(PAT_W + 1);

    // Only PAT_W-1 history bits are stored: the oldest bit would fall
    // out of the compare window anyway.
    logic [PAT_W-1:0] pat_q,  pat_d;
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic             det_q,  det_d;

    logic [PAT_W-1:0] window;
    logic             hit;
    logic             hit_eff;

    assign window  = {hist_q, bus.in_i};
    assign hit     = bus.en_i && (fill_q >= FILL_W'(PAT_W - 1)) && (window == pat_q);
    // A sample arriving with a pattern reload is discarded.
    assign hit_eff = hit && !bus.pat_load_i;

    // Next-state: pattern reload, sampling, fill tracking and detect.
    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        det_d  = hit_eff;
        if (bus.pat_load_i) begin
            pat_d  = bus.pat_in_i;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.en_i) begin
            hist_d = window[PAT_W-2:0];
            if (hit && !OVERLAP) begin
                fill_d = '0;
            end else if (fill_q != FILL_W'(PAT_W)) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    // State registers; reset restores the reset-time pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            det_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            det_q  <= det_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit_eff),
        .cnt (bus.match_cnt_o)
    );

    assign bus.out_o = (MOORE == MODE_MOORE) ? det_q : (hit_eff && !rst);

endmodule

// File: tb/tb_seq_detector_n.sv
// Directed bench for seq_detector_n: four instances share one stimulus
// stream (A: default Moore/overlap, B: no overlap, C: Mealy, D: 2-bit counter).
module tb_seq_detector_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_s = 1'b0;
    logic       en_s = 1'b0;
    logic       pat_load_s = 1'b0;
    logic [3:0] pat_in_s = 4'b0000;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detector_n_if #(.PAT_W(4), .CNT_W(8)) if_a ();
    seq_detector_n_if #(.PAT_W(4), .CNT_W(8)) if_b ();
    seq_detector_n_if #(.PAT_W(4), .CNT_W(8)) if_c ();
    seq_detector_n_if #(.PAT_W(4), .CNT_W(2)) if_d ();

    assign if_a.in_i = in_s;  assign if_a.en_i = en_s;
    assign if_a.pat_load_i = pat_load_s;  assign if_a.pat_in_i = pat_in_s;
    assign if_b.in_i = in_s;  assign if_b.en_i = en_s;
    assign if_b.pat_load_i = pat_load_s;  assign if_b.pat_in_i = pat_in_s;
    assign if_c.in_i = in_s;  assign if_c.en_i = en_s;
    assign if_c.pat_load_i = pat_load_s;  assign if_c.pat_in_i = pat_in_s;
    assign if_d.in_i = in_s;  assign if_d.en_i = en_s;
    assign if_d.pat_load_i = pat_load_s;  assign if_d.pat_in_i = pat_in_s;

    seq_detector_n #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MOORE(1'b1), .CNT_W(8))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    seq_detector_n #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .MOORE(1'b1), .CNT_W(8))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    seq_detector_n #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(8))
        dut_c (.clk(clk), .rst(rst), .bus(if_c));
    seq_detector_n #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MOORE(1'b1), .CNT_W(2))
        dut_d (.clk(clk), .rst(rst), .bus(if_d));

    task automatic step(input logic b, input logic e);
        in_s = b;
        en_s = e;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pat_load_s = 1'b0;
        en_s = 1'b0;
        in_s = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({if_a.out_o, if_b.out_o, if_c.out_o, if_d.out_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_out: got %b expected 0000",
                     {if_a.out_o, if_b.out_o, if_c.out_o, if_d.out_o});
        end
        checks++;
        if (if_a.match_cnt_o !== 8'd0 || if_b.match_cnt_o !== 8'd0 ||
            if_c.match_cnt_o !== 8'd0 || if_d.match_cnt_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_cnt: got a=%0d b=%0d c=%0d d=%0d expected all 0",
                     if_a.match_cnt_o, if_b.match_cnt_o, if_c.match_cnt_o, if_d.match_cnt_o);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] s;
        logic       exp_a;
        logic       exp_b;
        s = 7'b1011011;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            step(s[i], 1'b1);
            exp_a = (i == 3) || (i == 0);
            exp_b = (i == 3);
            checks++;
            if (if_a.out_o !== exp_a) begin
                errors++;
                $display("FAIL overlap_out_a bit%0d: got %b expected %b", 7 - i, if_a.out_o, exp_a);
            end
            checks++;
            if (if_b.out_o !== exp_b) begin
                errors++;
                $display("FAIL nooverlap_out_b bit%0d: got %b expected %b", 7 - i, if_b.out_o, exp_b);
            end
        end
        checks++;
        if (if_a.match_cnt_o !== 8'd2) begin
            errors++;
            $display("FAIL overlap_cnt_a: got %0d expected 2", if_a.match_cnt_o);
        end
        checks++;
        if (if_b.match_cnt_o !== 8'd1) begin
            errors++;
            $display("FAIL nooverlap_cnt_b: got %0d expected 1", if_b.match_cnt_o);
        end
    endtask

    task automatic test_no_overlap();
        logic [7:0] s;
        logic       exp_b;
        s = 8'b10111011;
        do_reset();
        for (int i = 7; i >= 0; i--) begin
            step(s[i], 1'b1);
            exp_b = (i == 4) || (i == 0);
            checks++;
            if (if_b.out_o !== exp_b) begin
                errors++;
                $display("FAIL nooverlap2_out_b bit%0d: got %b expected %b", 8 - i, if_b.out_o, exp_b);
            end
        end
        checks++;
        if (if_b.match_cnt_o !== 8'd2) begin
            errors++;
            $display("FAIL nooverlap2_cnt_b: got %0d expected 2", if_b.match_cnt_o);
        end
    endtask

    task automatic test_mealy();
        do_reset();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        in_s = 1'b1;
        en_s = 1'b1;
        #1;
        checks++;
        if (if_c.out_o !== 1'b1) begin
            errors++;
            $display("FAIL mealy_same_cycle: got %b expected 1", if_c.out_o);
        end
        en_s = 1'b0;
        #1;
        checks++;
        if (if_c.out_o !== 1'b0) begin
            errors++;
            $display("FAIL mealy_en_low: got %b expected 0", if_c.out_o);
        end
        en_s = 1'b1;
        @(posedge clk);
        #1;
        en_s = 1'b0;
        checks++;
        if (if_a.out_o !== 1'b1) begin
            errors++;
            $display("FAIL moore_latency: got %b expected 1", if_a.out_o);
        end
        checks++;
        if (if_c.match_cnt_o !== 8'd1) begin
            errors++;
            $display("FAIL mealy_cnt: got %0d expected 1", if_c.match_cnt_o);
        end
    endtask

    task automatic test_en_gating();
        do_reset();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            checks++;
            if (if_a.out_o !== 1'b0) begin
                errors++;
                $display("FAIL en_gap_out gap%0d: got %b expected 0", i, if_a.out_o);
            end
        end
        step(1'b1, 1'b1);
        checks++;
        if (if_a.out_o !== 1'b1) begin
            errors++;
            $display("FAIL en_gap_detect: got %b expected 1", if_a.out_o);
        end
        do_reset();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        checks++;
        if (if_a.out_o !== 1'b0 || if_a.match_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL en_zero_sampled: got out=%b cnt=%0d expected out=0 cnt=0",
                     if_a.out_o, if_a.match_cnt_o);
        end
    endtask

    task automatic test_pat_load();
        logic [6:0] s;
        logic       exp_a;
        s = 7'b1011101;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            step(s[i], 1'b1);
        end
        checks++;
        if (if_a.match_cnt_o !== 8'd1) begin
            errors++;
            $display("FAIL load_pre_cnt: got %0d expected 1", if_a.match_cnt_o);
        end
        pat_load_s = 1'b1;
        pat_in_s = 4'b0000;
        in_s = 1'b1;
        en_s = 1'b1;
        #1;
        checks++;
        if (if_c.out_o !== 1'b0) begin
            errors++;
            $display("FAIL load_mealy_block: got %b expected 0", if_c.out_o);
        end
        @(posedge clk);
        #1;
        pat_load_s = 1'b0;
        checks++;
        if (if_a.out_o !== 1'b0 || if_a.match_cnt_o !== 8'd1) begin
            errors++;
            $display("FAIL load_discard: got out=%b cnt=%0d expected out=0 cnt=1",
                     if_a.out_o, if_a.match_cnt_o);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1);
            exp_a = (i >= 3);
            checks++;
            if (if_a.out_o !== exp_a) begin
                errors++;
                $display("FAIL load_zeros_out zero%0d: got %b expected %b", i + 1, if_a.out_o, exp_a);
            end
        end
        checks++;
        if (if_a.match_cnt_o !== 8'd4 || if_c.match_cnt_o !== 8'd4) begin
            errors++;
            $display("FAIL load_cnt: got a=%0d c=%0d expected 4", if_a.match_cnt_o, if_c.match_cnt_o);
        end
    endtask

    task automatic test_rst_over_load();
        rst = 1'b1;
        pat_load_s = 1'b1;
        pat_in_s = 4'b0000;
        en_s = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pat_load_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1);
        end
        checks++;
        if (if_a.out_o !== 1'b0 || if_a.match_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL rst_load_zeros: got out=%b cnt=%0d expected out=0 cnt=0",
                     if_a.out_o, if_a.match_cnt_o);
        end
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        checks++;
        if (if_a.out_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_load_default_pat: got %b expected 1", if_a.out_o);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        step(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1);
            step(1'b1, 1'b1);
            step(1'b1, 1'b1);
        end
        en_s = 1'b0;
        checks++;
        if (if_d.match_cnt_o !== 2'd3) begin
            errors++;
            $display("FAIL sat_cnt_d: got %0d expected 3", if_d.match_cnt_o);
        end
        checks++;
        if (if_a.match_cnt_o !== 8'd5) begin
            errors++;
            $display("FAIL sat_cnt_a: got %0d expected 5", if_a.match_cnt_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        rst = 1'b1;
        in_s = 1'b1;
        en_s = 1'b1;
        #1;
        checks++;
        if (if_c.out_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mealy_forced: got %b expected 0", if_c.out_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 1'b1);
        checks++;
        if (if_a.out_o !== 1'b0 || if_a.match_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL rst_mid_pattern: got out=%b cnt=%0d expected out=0 cnt=0",
                     if_a.out_o, if_a.match_cnt_o);
        end
        en_s = 1'b0;
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_no_overlap();
        test_mealy();
        test_en_gating();
        test_pat_load();
        test_rst_over_load();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_detector_n.md
# seq_detector_n

Parametrised serial sequence detector: the next generation of the fixed single-pattern FSM detector. It watches a 1-bit serial stream and flags every occurrence of a PAT_W-bit pattern. Overlap handling and Moore/Mealy output style are compile-time selectable, the pattern can be reloaded at run time, and a saturating match counter is provided. It sits on a serial input behind a sample strobe and feeds status/interrupt logic.

## Interface
- PAT_W, 4: pattern length in bits; legal range 2..16.
- PATTERN, 4'b1011: reset-time pattern; MSB is the first bit received.
- OVERLAP, 1: 1 means matches may share bits; 0 means the bits of a match are consumed.
- MOORE, 1: 1 means registered detect output; 0 means combinational (Mealy) detect output.
- CNT_W, 8: width of the match counter.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in  in  1  serial data bit.
- en  in  1  sample strobe; `in` is consumed at an edge only when en=1.
- pat_load  in  1  load a new pattern at this edge.
- pat_in  in  PAT_W  new pattern value, MSB first.
- Output  out  1  detect pulse.
- match_cnt  out  CNT_W  saturating count of detections.

## Operation
- Internal state:
  - pattern register pat[PAT_W-1:0].
  - history shift register hist[PAT_W-1:0], newest bit at LSB.
  - fill counter fill in 0..PAT_W, saturating at PAT_W; this acts as the FSM state, i.e. bits collected toward a match.
- Sample (en=1, no pat_load, no rst):
  - hist <= {hist[PAT_W-2:0], in}.
  - fill <= min(fill+1, PAT_W).
- Detection condition: hit = en & (fill >= PAT_W-1) & ({hist[PAT_W-2:0], in} == pat).
- On hit:
  - OVERLAP=1: fill updates normally, so later matches may reuse the trailing bits.
  - OVERLAP=0: fill <= 0, so the next match needs PAT_W fresh sampled bits.
  - match_cnt <= match_cnt+1, holding at all-ones once saturated.
- en=0: no state change and no detection.
- pat_load=1 (rst=0):
  - pat <= pat_in; hist <= 0; fill <= 0; the Moore Output register <= 0.
  - Any sample presented in the same cycle is discarded and cannot hit.
  - match_cnt is kept.
- rst=1 has priority over everything:
  - pat <= PATTERN; hist <= 0; fill <= 0; match_cnt <= 0; Output register <= 0.
  - Mealy Output is forced to 0 while rst=1.
- Reset values: Output=0 and match_cnt=0 in both modes.

## Timing
- MOORE=1:
  - Output is a flop set to hit at each edge.
  - It is high for exactly one cycle after the edge that sampled the completing bit, independent of en in that cycle.
  - Back-to-back hits (e.g. an all-ones pattern with overlap) hold Output high on consecutive cycles.
- MOORE=0:
  - Output = hit & ~rst & ~pat_load, combinational from in/en.
  - It is valid in the same cycle the completing bit is presented, before the edge.
- match_cnt updates at the same edge in both modes, and shows the new value one cycle after the completing bit is sampled.
- Detection latency from the last pattern bit: 0 cycles for Mealy, 1 cycle for Moore.
- Simultaneous rst and pat_load: rst wins, and pat = PATTERN.
- Reset mid-pattern: partial progress is lost, and the stream must restart from the first pattern bit.

## Structure
- Shared package seq_det_pkg:
  - mode constants MODE_MOORE=1, MODE_MEALY=0.
  - PAT_W_MIN=2 and PAT_W_MAX=16.
  - an elaboration-time check of the PAT_W range.
- One natural sub-module: sat_counter (parameter W; ports clk, rst, inc, cnt), instantiated for match_cnt.
- Everything else (history, fill, compare, output) stays flat in seq_detector_n.

## Test plan
- Defaults (1011, OVERLAP=1, Moore), en=1, stream 1,0,1,1,0,1,1:
  - Output high in the cycle after bits 4 and 7.
  - match_cnt=2.
- OVERLAP=0, same stream 1011011: one detect only (after bit 4), match_cnt=1. Stream 10111011 gives two detects.
- MOORE=0 with stream 1011: Output is high combinationally while the 4th bit (1) is presented with en=1, and low if en is dropped in that cycle.
- en gating: stream 1,0,1 with en=1, then an en=0 gap of 3 cycles with in=0, then 1 with en=1 -> detect. A zero sampled with en=1 instead -> no detect.
- pat_load: assert with pat_in=4'b0000 while stream 101 is partial, then six 0s -> 3 detects (overlap), match_cnt incremented by 3 and not cleared by the load.
- Boundaries:
  - CNT_W=2 with 5 detects -> match_cnt holds at 3.
  - rst pulse after stream 101, then 1 -> no detect, match_cnt=0, Output=0.
